block_stats_sp: RTL and testbench

- Downstream consumer of the single-port ping-pong sample buffer.
- Claims each completed buffer with the buf_ready/buf_take handshake, then drains the BUF_LEN samples over the rd_valid/rd_ready/rd_last stream.
- Computes per-block statistics: signed sum, sum of squares (energy) and peak magnitude.
- Presents one result word per block to the detection/control logic over a valid/ready interface.

---
 rtl/block_stats_sp.sv | 154 +++++++++++++++
 tb/tb_block_stats_sp.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_stats_sp.sv
// block_stats_sp: per-block statistics engine behind the ping-pong sample buffer.
// Claims a completed buffer (buf_ready_i/buf_take_o), drains it over the
// rd_valid_i/rd_ready_o/rd_last_i stream and reports signed sum, energy (sum of
// squares) and peak magnitude as one result word over res_valid_o/res_ready_i.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   buf_ready_i/buf_id_i  buffer available and its ID
//   buf_take_o          one-cycle claim pulse
//   rd_data_i/rd_valid_i/rd_ready_o/rd_last_i  sample stream
//   res_sum_o/res_energy_o/res_peak_o/res_buf_id_o/res_len_err_o  result word
//   res_valid_o/res_ready_i  result handshake
//   busy_o              engine not idle
module block_stats_sp #(
  parameter int SAMPLE_W = 16,
  parameter int BUF_LEN  = 256,
  parameter int CNT_W    = $clog2(BUF_LEN) + 1,
  parameter int SUM_W    = SAMPLE_W + $clog2(BUF_LEN),
  parameter int NRG_W    = 2 * SAMPLE_W + $clog2(BUF_LEN)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                buf_ready_i,
  input  logic                buf_id_i,
  output logic                buf_take_o,
  input  logic [SAMPLE_W-1:0] rd_data_i,
  input  logic                rd_valid_i,
  output logic                rd_ready_o,
  input  logic                rd_last_i,
  output logic [SUM_W-1:0]    res_sum_o,
  output logic [NRG_W-1:0]    res_energy_o,
  output logic [SAMPLE_W-1:0] res_peak_o,
  output logic                res_buf_id_o,
  output logic                res_len_err_o,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic                busy_o
);

  typedef enum logic [1:0] {StIdle, StTake, StRead, StDone} state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [NRG_W-1:0]    nrg_q, nrg_d;
  logic [SAMPLE_W-1:0] peak_q, peak_d;
  logic                id_q, id_d;
  logic                err_q, err_d;

  // Moore outputs are registered from the next state so they are glitch-free.
  logic take_q, rdy_q, vld_q, busy_q;

  logic                  at_full;
  logic                  blk_end;
  logic [2*SAMPLE_W-1:0] smp_wide;
  logic [2*SAMPLE_W-1:0] smp_sq;
  logic [SAMPLE_W-1:0]   smp_mag;

  // cnt_q counts samples already accepted, so the BUF_LEN-th sample sees BUF_LEN-1.
  assign at_full  = (cnt_q == CNT_W'(BUF_LEN - 1));
  assign blk_end  = rd_last_i || at_full;
  assign smp_wide = {{SAMPLE_W{rd_data_i[SAMPLE_W-1]}}, rd_data_i};
  // Square is never negative, so the low 2*SAMPLE_W bits are its unsigned value.
  assign smp_sq   = $signed(smp_wide) * $signed(smp_wide);
  // Negating the most negative sample wraps to 2^(SAMPLE_W-1), correct as unsigned.
  assign smp_mag  = rd_data_i[SAMPLE_W-1] ? ('0 - rd_data_i) : rd_data_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    nrg_d   = nrg_q;
    peak_d  = peak_q;
    id_d    = id_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (buf_ready_i) begin
          state_d = StTake;
          id_d    = buf_id_i;
        end
      end
      StTake: begin
        state_d = StRead;
        cnt_d   = '0;
        sum_d   = '0;
        nrg_d   = '0;
        peak_d  = '0;
        err_d   = 1'b0;
      end
      StRead: begin
        if (rd_valid_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          sum_d = sum_q + {{(SUM_W - SAMPLE_W){rd_data_i[SAMPLE_W-1]}}, rd_data_i};
          nrg_d = nrg_q + {{(NRG_W - 2 * SAMPLE_W){1'b0}}, smp_sq};
          if (smp_mag > peak_q) begin
            peak_d = smp_mag;
          end
          if (blk_end) begin
            state_d = StDone;
            // Error unless rd_last lands exactly on the BUF_LEN-th sample.
            err_d   = rd_last_i ^ at_full;
          end
        end
      end
      StDone: begin
        if (res_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sum_q   <= '0;
      nrg_q   <= '0;
      peak_q  <= '0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      take_q  <= 1'b0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      nrg_q   <= nrg_d;
      peak_q  <= peak_d;
      id_q    <= id_d;
      err_q   <= err_d;
      take_q  <= (state_d == StTake);
      rdy_q   <= (state_d == StRead);
      vld_q   <= (state_d == StDone);
      busy_q  <= (state_d != StIdle);
    end
  end

  assign buf_take_o    = take_q;
  assign rd_ready_o    = rdy_q;
  assign res_valid_o   = vld_q;
  assign busy_o        = busy_q;
  assign res_sum_o     = sum_q;
  assign res_energy_o  = nrg_q;
  assign res_peak_o    = peak_q;
  assign res_buf_id_o  = id_q;
  assign res_len_err_o = err_q;

endmodule

// File: tb/tb_block_stats_sp.sv
// tb_block_stats_sp: self-checking bench for block_stats_sp. Expected result
// words are computed from the driven block and queued; a monitor queues every
// accepted result word and each scenario task pops and compares the pair.
module tb_block_stats_sp;

  localparam int SW    = 16;
  localparam int BL    = 256;
  localparam int SUM_W = SW + $clog2(BL);
  localparam int NRG_W = 2 * SW + $clog2(BL);

  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic [NRG_W-1:0] nrg;
    logic [SW-1:0]    peak;
    logic             id;
    logic             err;
  } res_t;

  logic             clk;
  logic             rst_i;
  logic             buf_ready_i;
  logic             buf_id_i;
  logic             buf_take_o;
  logic [SW-1:0]    rd_data_i;
  logic             rd_valid_i;
  logic             rd_ready_o;
  logic             rd_last_i;
  logic [SUM_W-1:0] res_sum_o;
  logic [NRG_W-1:0] res_energy_o;
  logic [SW-1:0]    res_peak_o;
  logic             res_buf_id_o;
  logic             res_len_err_o;
  logic             res_valid_o;
  logic             res_ready_i;
  logic             busy_o;

  block_stats_sp #(.SAMPLE_W(SW), .BUF_LEN(BL)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .buf_ready_i  (buf_ready_i),
    .buf_id_i     (buf_id_i),
    .buf_take_o   (buf_take_o),
    .rd_data_i    (rd_data_i),
    .rd_valid_i   (rd_valid_i),
    .rd_ready_o   (rd_ready_o),
    .rd_last_i    (rd_last_i),
    .res_sum_o    (res_sum_o),
    .res_energy_o (res_energy_o),
    .res_peak_o   (res_peak_o),
    .res_buf_id_o (res_buf_id_o),
    .res_len_err_o(res_len_err_o),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .busy_o       (busy_o)
  );

  logic [SUM_W+NRG_W+SW+5:0] all_out;
  assign all_out = {buf_take_o, rd_ready_o, res_sum_o, res_energy_o, res_peak_o,
                    res_buf_id_o, res_len_err_o, res_valid_o, busy_o};

  logic [SW-1:0] blk [BL];
  res_t          exp_q[$];
  res_t          got_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Result accepted at the coming edge: inputs change only just after posedge.
  always @(negedge clk) begin
    if (!rst_i && res_valid_o && res_ready_i) begin
      got_q.push_back(res_t'({res_sum_o, res_energy_o, res_peak_o, res_buf_id_o, res_len_err_o}));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic string fmt(input res_t r);
    return $sformatf("sum=%0d nrg=%0d peak=%h id=%0b err=%0b",
                     $signed(r.sum), r.nrg, r.peak, r.id, r.err);
  endfunction

  // Independent integer model over the first n samples of blk.
  function automatic res_t model(input int n, input logic id, input logic err);
    res_t   r;
    longint s = 0;
    longint e = 0;
    int     p = 0;
    int     v;
    for (int i = 0; i < n; i++) begin
      v = int'($signed(blk[i]));
      s += v;
      e += longint'(v) * longint'(v);
      if ((v < 0 ? -v : v) > p) p = (v < 0 ? -v : v);
    end
    r.sum  = SUM_W'(s);
    r.nrg  = NRG_W'(e);
    r.peak = SW'(p);
    r.id   = id;
    r.err  = err;
    return r;
  endfunction

  task automatic fill_ramp(input logic [SW-1:0] base);
    for (int i = 0; i < BL; i++) blk[i] = base + SW'(i);
  endtask

  task automatic fill_const(input logic [SW-1:0] v);
    for (int i = 0; i < BL; i++) blk[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < BL; i++) blk[i] = SW'($urandom);
    blk[7] = 16'h8000;
  endtask

  // Offers buffer id, then streams blk[0..n_send-1]; rd_valid is already high
  // during IDLE/TAKE so those cycles exercise the ignore path.
  task automatic run_block(input logic id, input int n_send, input int last_idx,
                           output int accepted, output int takes, output int overlap,
                           output int take_cyc);
    bit will;
    accepted = 0;
    takes    = 0;
    overlap  = 0;
    take_cyc = -1;
    buf_ready_i = 1'b1;
    buf_id_i    = id;
    for (int c = 0; c < n_send + 20 && accepted < n_send; c++) begin
      rd_valid_i = 1'b1;
      rd_data_i  = blk[accepted];
      rd_last_i  = (accepted == last_idx);
      if (buf_take_o) begin
        takes++;
        if (take_cyc < 0) take_cyc = cyc;
        buf_ready_i = 1'b0;
        if (rd_ready_o) overlap++;
      end
      will = rd_ready_o;
      step();
      if (will) accepted++;
    end
    rd_valid_i  = 1'b0;
    rd_last_i   = 1'b0;
    buf_ready_i = 1'b0;
  endtask

  task automatic take_result(output res_t g, output res_t e, output bit ok);
    int n = 0;
    while (got_q.size() == 0 && n < 40) begin
      step();
      n++;
    end
    ok = (got_q.size() != 0) && (exp_q.size() != 0);
    g  = '0;
    e  = '0;
    if (ok) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
    end else begin
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    rd_valid_i = 1'b1;
    buf_ready_i = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (all_out !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h need 0", all_out);
    end
    rst_i = 1'b0;
    buf_ready_i = 1'b0;
    rd_valid_i = 1'b0;
    step();
    n_cmp++;
    if (all_out !== '0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got %h need 0", all_out);
    end
  endtask

  task automatic test_ramp();
    int acc, tk, ov, tc;
    res_t g, e;
    bit ok;
    fill_ramp(16'h1000);
    res_ready_i = 1'b1;
    exp_q.push_back(model(BL, 1'b0, 1'b0));
    run_block(1'b0, BL, BL - 1, acc, tk, ov, tc);
    n_cmp++;
    if (tk !== 1) begin
      n_bad++;
      $display("FAIL ramp_take_pulse: got %0d cycles need 1", tk);
    end
    n_cmp++;
    if (ov !== 0) begin
      n_bad++;
      $display("FAIL ramp_ready_in_take: got %0d need 0", ov);
    end
    n_cmp++;
    if (res_valid_o !== 1'b1) begin
      n_bad++;
      $display("FAIL ramp_latency: res_valid got %b need 1", res_valid_o);
    end
    take_result(g, e, ok);
    n_cmp++;
    if (!ok || g !== e || acc !== BL) begin
      n_bad++;
      $display("FAIL ramp_result: got %s (acc %0d) need %s (acc %0d)", fmt(g), acc, fmt(e), BL);
    end
  endtask

  task automatic test_min();
    int acc, tk, ov, tc;
    res_t g, e;
    bit ok;
    fill_const(16'h8000);
    res_ready_i = 1'b1;
    exp_q.push_back(model(BL, 1'b1, 1'b0));
    run_block(1'b1, BL, BL - 1, acc, tk, ov, tc);
    take_result(g, e, ok);
    n_cmp++;
    if (!ok || g !== e || acc !== BL) begin
      n_bad++;
      $display("FAIL min_result: got %s (acc %0d) need %s (acc %0d)", fmt(g), acc, fmt(e), BL);
    end
  endtask

  task automatic test_early_last();
    int acc, tk, ov, tc;
    res_t g, e;
    bit ok;
    fill_ramp(16'hff80);
    res_ready_i = 1'b1;
    exp_q.push_back(model(100, 1'b0, 1'b1));
    run_block(1'b0, 100, 99, acc, tk, ov, tc);
    n_cmp++;
    if (res_valid_o !== 1'b1 || rd_ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL early_last_stop: valid=%b ready=%b need valid=1 ready=0",
               res_valid_o, rd_ready_o);
    end
    take_result(g, e, ok);
    n_cmp++;
    if (!ok || g !== e || acc !== 100) begin
      n_bad++;
      $display("FAIL early_last_result: got %s (acc %0d) need %s (acc 100)", fmt(g), acc, fmt(e));
    end
  endtask

  task automatic test_missing_last();
    int acc, tk, ov, tc;
    res_t g, e;
    bit ok;
    fill_const(16'h0001);
    res_ready_i = 1'b1;
    exp_q.push_back(model(BL, 1'b1, 1'b1));
    run_block(1'b1, BL, -1, acc, tk, ov, tc);
    n_cmp++;
    if (res_valid_o !== 1'b1 || rd_ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL missing_last_stop: valid=%b ready=%b need valid=1 ready=0",
               res_valid_o, rd_ready_o);
    end
    take_result(g, e, ok);
    n_cmp++;
    if (!ok || g !== e || acc !== BL) begin
      n_bad++;
      $display("FAIL missing_last_result: got %s (acc %0d) need %s", fmt(g), acc, fmt(e));
    end
  endtask

  task automatic test_backpressure();
    int acc, tk, ov, tc;
    int take_bad = 0;
    int stable_bad = 0;
    logic [SUM_W+NRG_W+SW+5:0] snap;
    res_t g, e;
    bit ok;
    fill_rand();
    res_ready_i = 1'b0;
    exp_q.push_back(model(BL, 1'b0, 1'b0));
    run_block(1'b0, BL, BL - 1, acc, tk, ov, tc);
    snap = all_out;
    buf_ready_i = 1'b1;
    buf_id_i = 1'b1;
    repeat (50) begin
      step();
      if (buf_take_o !== 1'b0) take_bad++;
      if (all_out !== snap) stable_bad++;
    end
    n_cmp++;
    if (take_bad !== 0) begin
      n_bad++;
      $display("FAIL bp_no_take: got %0d take cycles need 0", take_bad);
    end
    n_cmp++;
    if (stable_bad !== 0 || res_valid_o !== 1'b1 || busy_o !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_stable: changes=%0d valid=%b busy=%b need 0/1/1",
               stable_bad, res_valid_o, busy_o);
    end
    res_ready_i = 1'b1;
    step();
    res_ready_i = 1'b0;
    n_cmp++;
    if (buf_take_o !== 1'b0 || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_idle_after_accept: take=%b busy=%b need 0/0", buf_take_o, busy_o);
    end
    step();
    n_cmp++;
    if (buf_take_o !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_take_after_idle: take=%b need 1", buf_take_o);
    end
    take_result(g, e, ok);
    n_cmp++;
    if (!ok || g !== e || acc !== BL) begin
      n_bad++;
      $display("FAIL bp_held_result: got %s need %s", fmt(g), fmt(e));
    end
    fill_rand();
    res_ready_i = 1'b1;
    exp_q.push_back(model(BL, 1'b1, 1'b0));
    run_block(1'b1, BL, BL - 1, acc, tk, ov, tc);
    take_result(g, e, ok);
    n_cmp++;
    if (!ok || g !== e || acc !== BL) begin
      n_bad++;
      $display("FAIL bp_next_result: got %s need %s", fmt(g), fmt(e));
    end
  endtask

  task automatic test_back_to_back();
    int acc0, acc1, tk, ov, t0, t1;
    res_t g, e;
    bit ok;
    res_ready_i = 1'b1;
    fill_rand();
    exp_q.push_back(model(BL, 1'b0, 1'b0));
    run_block(1'b0, BL, BL - 1, acc0, tk, ov, t0);
    fill_rand();
    exp_q.push_back(model(BL, 1'b1, 1'b0));
    run_block(1'b1, BL, BL - 1, acc1, tk, ov, t1);
    n_cmp++;
    if (t1 - t0 !== BL + 3) begin
      n_bad++;
      $display("FAIL b2b_period: got %0d cycles need %0d", t1 - t0, BL + 3);
    end
    take_result(g, e, ok);
    n_cmp++;
    if (!ok || g !== e || acc0 !== BL) begin
      n_bad++;
      $display("FAIL b2b_first: got %s need %s", fmt(g), fmt(e));
    end
    take_result(g, e, ok);
    n_cmp++;
    if (!ok || g !== e || acc1 !== BL) begin
      n_bad++;
      $display("FAIL b2b_second: got %s need %s", fmt(g), fmt(e));
    end
  endtask

  task automatic test_reset_mid();
    int acc, tk, ov, tc;
    res_t g, e;
    bit ok;
    res_ready_i = 1'b1;
    fill_ramp(16'h2000);
    run_block(1'b0, 60, -1, acc, tk, ov, tc);
    rst_i = 1'b1;
    step();
    n_cmp++;
    if (all_out !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got %h need 0", all_out);
    end
    step();
    rst_i = 1'b0;
    fill_rand();
    exp_q.push_back(model(BL, 1'b1, 1'b0));
    run_block(1'b1, BL, BL - 1, acc, tk, ov, tc);
    take_result(g, e, ok);
    n_cmp++;
    if (!ok || g !== e || acc !== BL) begin
      n_bad++;
      $display("FAIL mid_reset_fresh: got %s need %s", fmt(g), fmt(e));
    end
    repeat (3) step();
    n_cmp++;
    if (got_q.size() !== 0) begin
      n_bad++;
      $display("FAIL mid_reset_extra: got %0d extra results need 0", got_q.size());
    end
  endtask

  initial begin
    rst_i = 1'b1;
    buf_ready_i = 1'b0;
    buf_id_i = 1'b0;
    rd_data_i = '0;
    rd_valid_i = 1'b0;
    rd_last_i = 1'b0;
    res_ready_i = 1'b0;
    test_reset();
    test_ramp();
    test_min();
    test_early_last();
    test_missing_last();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
